// File: rtl/irq_ctrl_pkg.sv
// Shared peripheral definitions: register offsets, FSM encoding, default base address.
// No logic of its own; the address-match helper is purely combinational.
// Backpressure: not applicable.
package irq_ctrl_pkg;

    localparam logic [31:0] IRQ_BASE_ADDR = 32'h4000_0020;

    localparam logic [31:0] OFF_IMASK = 32'h0;
    localparam logic [31:0] OFF_IPEND = 32'h4;
    localparam logic [31:0] OFF_ICTRL = 32'h8;

    localparam int ICTRL_GIE_BIT   = 0;
    localparam int ICTRL_INSVC_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    // True when a byte address selects the register at base+off.
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] off);
        return addr == (base + off);
    endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Priority encoder: index of the lowest set bit of vec_i (bit 0 wins), plus any-set flag.
// Latency: purely combinational.
// Backpressure: none.
module prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] vec_i,
    output logic [2:0]   idx_o,
    output logic         vld_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx_o = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = 3'(i);
            end
        end
        vld_o = |vec_i;
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-captured sources, mask/pending/control registers, one-deep request FSM.
// Latency: src rising edge at N -> IPEND at N+1 -> irq_out at N+2; bus reads are combinational.
// Backpressure: a raised request is held until irq_ack; new edges queue in IPEND, no nesting.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] BASE_ADDR = IRQ_BASE_ADDR
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [31:0]      Address,
    input  logic [31:0]      WriteData,
    output logic [31:0]      ReadData,
    output logic             irq_out,
    output logic [2:0]       irq_id,
    input  logic             irq_ack,
    input  logic             irq_done
);

    logic [N_SRC-1:0] src_q;
    logic             armed_q;
    logic [N_SRC-1:0] imask_q, imask_d;
    logic [N_SRC-1:0] ipend_q, ipend_d;
    logic             gie_q, gie_d;
    irq_state_e       state_q, state_d;
    logic [2:0]       irq_id_q, irq_id_d;

    logic [N_SRC-1:0] src_rise;
    logic [N_SRC-1:0] pend_masked;
    logic [N_SRC-1:0] ack_clr;
    logic [2:0]       enc_idx;
    logic             enc_vld;
    logic             in_service;
    logic             ack_take;
    logic             hit_imask, hit_ipend, hit_ictrl;
    logic             unused_wdata;

    assign hit_imask = addr_hit(Address, BASE_ADDR, OFF_IMASK);
    assign hit_ipend = addr_hit(Address, BASE_ADDR, OFF_IPEND);
    assign hit_ictrl = addr_hit(Address, BASE_ADDR, OFF_ICTRL);

    // armed_q stays low for the first post-reset cycle so a level already high is absorbed into src_q.
    assign src_rise     = src & ~src_q & {N_SRC{armed_q}};
    assign pend_masked  = ipend_q & imask_q;
    assign ack_take     = (state_q == ST_REQ) && irq_ack;
    assign ack_clr      = N_SRC'(1) << irq_id_q;
    assign unused_wdata = ^WriteData[31:N_SRC];

    prio_enc #(.N(N_SRC)) u_prio_enc (
        .vec_i (pend_masked),
        .idx_o (enc_idx),
        .vld_o (enc_vld)
    );

    // Register next-state: bus writes and ack-clear first, then edge-set so a new edge always wins.
    always_comb begin
        imask_d = imask_q;
        gie_d   = gie_q;
        ipend_d = ipend_q;
        if (MemWrite && hit_imask) begin
            imask_d = WriteData[N_SRC-1:0];
        end
        if (MemWrite && hit_ictrl) begin
            gie_d = WriteData[ICTRL_GIE_BIT];
        end
        if (MemWrite && hit_ipend) begin
            ipend_d = ipend_d & ~WriteData[N_SRC-1:0];
        end
        if (ack_take) begin
            ipend_d = ipend_d & ~ack_clr;
        end
        ipend_d = ipend_d | src_rise;
    end

    // Register and source-sampling state.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            src_q   <= '0;
            armed_q <= 1'b0;
            imask_q <= '0;
            ipend_q <= '0;
            gie_q   <= 1'b0;
        end else begin
            src_q   <= src;
            armed_q <= 1'b1;
            imask_q <= imask_d;
            ipend_q <= ipend_d;
            gie_q   <= gie_d;
        end
    end

    // FSM state register; irq_id is captured only on the IDLE->REQ transition.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            irq_id_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            irq_id_q <= irq_id_d;
        end
    end

    // FSM next-state: a request, once raised, ignores mask/GIE/IPEND until acked.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                if (gie_q && enc_vld) begin
                    state_d  = ST_REQ;
                    irq_id_d = enc_idx;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (irq_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        irq_out    = (state_q == ST_REQ);
        in_service = (state_q == ST_SERVICE);
        irq_id     = irq_id_q;
    end

    // Bus read mux; zero unless a read hits a decoded register.
    always_comb begin
        ReadData = 32'h0;
        if (MemRead) begin
            if (hit_imask) begin
                ReadData = 32'(imask_q);
            end else if (hit_ipend) begin
                ReadData = 32'(ipend_q);
            end else if (hit_ictrl) begin
                ReadData[ICTRL_GIE_BIT]   = gie_q;
                ReadData[ICTRL_INSVC_BIT] = in_service;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register access, request latency, priority, W1C races, reset abandon.
// Inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// Every expected value below is hand-derived from the register/FSM behaviour.
module tb_irq_ctrl;

    localparam logic [31:0] BASE = 32'h4000_0020;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  src = 4'h0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic        irq_out;
    logic [2:0]  irq_id;
    logic        irq_ack = 1'b0;
    logic        irq_done = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    irq_ctrl #(.N_SRC(4), .BASE_ADDR(BASE)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .src       (src),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .irq_out   (irq_out),
        .irq_id    (irq_id),
        .irq_ack   (irq_ack),
        .irq_done  (irq_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] off, input logic [31:0] data);
        MemWrite  = 1'b1;
        Address   = BASE + off;
        WriteData = data;
        tick();
        MemWrite  = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
    endtask

    task automatic bus_rd(input logic [31:0] off, output logic [31:0] data);
        MemRead = 1'b1;
        Address = BASE + off;
        #1;
        data    = ReadData;
        MemRead = 1'b0;
        Address = 32'h0;
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] v;
        bus_rd(off, v);
        chk(tag, v, exp);
    endtask

    initial begin
        // Reset
        tick(); tick();
        reset = 1'b0;
        chk("rst_irq_out", 32'(irq_out), 32'h0);
        chk("rst_irq_id", 32'(irq_id), 32'h0);
        chk_reg("rst_imask", 32'h0, 32'h0);
        chk_reg("rst_ipend", 32'h4, 32'h0);
        chk_reg("rst_ictrl", 32'h8, 32'h0);

        // Single source: latency, ack clears pending, service status
        bus_wr(32'h0, 32'h1);
        bus_wr(32'h8, 32'h1);
        chk_reg("imask_rd", 32'h0, 32'h1);
        src = 4'b0001;
        tick();
        chk_reg("lat_ipend_n1", 32'h4, 32'h1);
        chk("lat_irq_n1", 32'(irq_out), 32'h0);
        src = 4'b0000;
        tick();
        chk("lat_irq_n2", 32'(irq_out), 32'h1);
        chk("lat_id_n2", 32'(irq_id), 32'h0);
        tick(); tick();
        chk("req_hold", 32'(irq_out), 32'h1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk_reg("ack_ipend", 32'h4, 32'h0);
        chk("ack_irq_out", 32'(irq_out), 32'h0);
        chk_reg("svc_ictrl", 32'h8, 32'h3);
        chk_reg("rd_unmapped", 32'hC, 32'h0);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        chk_reg("done_ictrl", 32'h8, 32'h1);

        // Priority, request stickiness under mask change, level-hold
        bus_wr(32'h0, 32'hF);
        src = 4'b1010;
        tick();
        tick();
        chk("prio_irq", 32'(irq_out), 32'h1);
        chk("prio_id1", 32'(irq_id), 32'h1);
        bus_wr(32'h0, 32'h0);
        chk("mask0_irq", 32'(irq_out), 32'h1);
        chk("mask0_id", 32'(irq_id), 32'h1);
        bus_wr(32'h0, 32'hF);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("ack2_irq", 32'(irq_out), 32'h0);
        chk_reg("ack2_ipend", 32'h4, 32'h8);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        chk("done2_gap", 32'(irq_out), 32'h0);
        tick();
        chk("second_irq", 32'(irq_out), 32'h1);
        chk("second_id3", 32'(irq_id), 32'h3);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        src = 4'b0000;
        tick();
        chk_reg("drain_ipend", 32'h4, 32'h0);

        // Edge-set vs W1C in the same cycle; stray ack/done ignored
        bus_wr(32'h8, 32'h0);
        src       = 4'b0001;
        MemWrite  = 1'b1;
        Address   = BASE + 32'h4;
        WriteData = 32'h1;
        tick();
        MemWrite  = 1'b0;
        Address   = 32'h0;
        WriteData = 32'h0;
        chk_reg("set_wins", 32'h4, 32'h1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk_reg("stray_ack", 32'h4, 32'h1);
        irq_done = 1'b1;
        tick();
        irq_done = 1'b0;
        chk_reg("stray_done", 32'h8, 32'h0);
        chk("gie0_no_irq", 32'(irq_out), 32'h0);
        bus_wr(32'h4, 32'h1);
        chk_reg("w1c_clear", 32'h4, 32'h0);
        src = 4'b0000;
        tick();

        // Reset in SERVICE abandons the request; held level makes no edge
        bus_wr(32'h0, 32'h1);
        bus_wr(32'h8, 32'h1);
        src = 4'b0001;
        tick();
        tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk_reg("pre_rst_ictrl", 32'h8, 32'h3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_irq_out", 32'(irq_out), 32'h0);
        chk("rst2_irq_id", 32'(irq_id), 32'h0);
        chk_reg("rst2_imask", 32'h0, 32'h0);
        chk_reg("rst2_ipend", 32'h4, 32'h0);
        chk_reg("rst2_ictrl", 32'h8, 32'h0);
        tick();
        tick();
        chk_reg("held_no_edge", 32'h4, 32'h0);
        src = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter: N_SRC, default 4, number of interrupt sources (max 8).
REQ-002 Parameter: BASE_ADDR, default 32'h4000_0020, word-aligned base of the register window.
REQ-003 Port: clk_in  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: src  input  N_SRC  level interrupt sources; src[0] driven by timer TCON[2].
REQ-006 Port: MemRead  input  1  bus read strobe.
REQ-007 Port: MemWrite  input  1  bus write strobe.
REQ-008 Port: Address  input  32  bus byte address.
REQ-009 Port: WriteData  input  32  bus write data.
REQ-010 Port: ReadData  output  32  bus read data, combinational.
REQ-011 Port: irq_out  output  1  interrupt request to CPU.
REQ-012 Port: irq_id  output  3  index of the requested source, valid while irq_out=1.
REQ-013 Port: irq_ack  input  1  CPU single-cycle pulse: interrupt taken (PC redirected to handler).
REQ-014 Port: irq_done  input  1  CPU single-cycle pulse: eret executed.

Function
REQ-015 Registers at BASE_ADDR+0x0 IMASK (N_SRC bits, RW), +0x4 IPEND (N_SRC bits, read; write-1-to-clear), +0x8 ICTRL (bit0 GIE RW; bit1 IN_SERVICE RO; other bits read 0).
REQ-016 Writes take effect on the clock edge with MemWrite=1 and a matching Address; unmatched addresses are ignored.
REQ-017 ReadData = selected register zero-extended when MemRead=1 and Address matches; otherwise 32'h0.
REQ-018 Each src bit is registered once (src_q); a rising edge (src & ~src_q) sets the corresponding IPEND bit the next cycle.
REQ-019 A level held high sets IPEND only once per rising edge.
REQ-020 Same-cycle edge-set and W1C on the same bit: set wins.
REQ-021 FSM states IDLE, REQ, SERVICE; reset state IDLE.
REQ-022 IDLE -> REQ when GIE=1 and (IPEND & IMASK) != 0; irq_id latched to the lowest-index pending, unmasked bit (index 0 highest priority).
REQ-023 In REQ, irq_out=1 and irq_id is held constant; mask, GIE, or IPEND changes do not retract or change the request.
REQ-024 REQ -> SERVICE on irq_ack=1; the same edge clears IPEND[irq_id] (an edge on that source in the same cycle keeps it set).
REQ-025 In SERVICE, irq_out=0 and IN_SERVICE=1; no nesting; new edges accumulate in IPEND.
REQ-026 SERVICE -> IDLE on irq_done=1; a further request may be raised no earlier than the following cycle.
REQ-027 irq_ack outside REQ and irq_done outside SERVICE are ignored.
REQ-028 Request-to-irq_out latency: src rising edge at cycle N -> IPEND set at N+1 -> irq_out=1 at N+2 (GIE=1, bit unmasked, state IDLE).

Reset
REQ-029 On reset=1 at a clock edge: IMASK=0, IPEND=0, GIE=0, src_q=0, state=IDLE, irq_out=0, irq_id=0; ReadData depends only on bus inputs and registers.
REQ-030 Reset mid-REQ or mid-SERVICE abandons the request without requiring irq_ack or irq_done.
REQ-031 A src level that is high when reset deasserts produces no edge, because src_q is captured on the first post-reset cycle.

Structure
REQ-032 Register offsets, the FSM state encoding, and BASE_ADDR default live in the shared peripheral package used by the timer.
REQ-033 The priority encoder (N_SRC-bit vector -> index, valid flag) is a separate sub-module, prio_enc.

Verification
REQ-034 GIE=1, IMASK=4'b0001; pulse src[0] high at cycle 10 -> IPEND=1 at 11, irq_out=1 and irq_id=0 at 12; irq_ack at 14 -> IPEND=0 and irq_out=0 at 15; irq_done at 20 -> IDLE.
REQ-035 IMASK=4'b1111; rise src[3] and src[1] in the same cycle -> irq_id=1; after ack and done, second request has irq_id=3.
REQ-036 In REQ, write IMASK=0 -> irq_out stays 1 with the same irq_id until irq_ack.
REQ-037 Write IPEND=32'h1 in the same cycle src[0] rises -> IPEND[0]=1.
REQ-038 Assert reset during SERVICE -> next cycle state IDLE, all registers 0, irq_out=0; src[0] held high -> no new IPEND bit.
REQ-039 Read BASE_ADDR+0x8 in SERVICE with GIE=1 -> ReadData=32'h3; read BASE_ADDR+0xC -> 32'h0.
